// File: rtl/sync_fifo_ctrl.sv
// Purpose: synchronous FIFO controller driving an external dual-port RAM (port 0 writes, port 1 reads asynchronously).
// Latency: one cycle from an accepted rd_en to valid data_out; occupancy flags follow the registered count.
// Backpressure: writes are rejected while full and reads while empty, with one-cycle overflow/underflow pulses.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH-1:0] ram_address_0,
    output logic                  ram_cs_0,
    output logic                  ram_we_0,
    output logic                  ram_oe_0,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_address_1,
    output logic                  ram_cs_1,
    output logic                  ram_we_1,
    output logic                  ram_oe_1,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    // Occupancy value that means "every RAM word holds live data".
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Flags come straight from the registered count, so accept decisions never loop back through the request inputs.
    always_comb begin
        w_full      = (r_count == DEPTH_CNT);
        w_empty     = (r_count == '0);
        // Full blocks writes even with a concurrent read so the RAM never sees a write and read on one address.
        w_wr_accept = wr_en && !w_full;
        // Empty blocks reads even with a concurrent write: there is no write-to-read bypass path.
        w_rd_accept = rd_en && !w_empty;
    end

    // Pointer, occupancy, read-data and error-pulse registers; reset wins over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Pointers are exactly ADDR_WIDTH bits, so DEPTH-1 wraps to 0 by natural overflow.
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= ram_rdata;
            end
            unique case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en && w_full;
            r_underflow <= rd_en && w_empty;
        end
    end

    // RAM port wiring: port 0 writes only on accepted writes outside reset, port 1 is a permanently enabled read port.
    always_comb begin
        ram_address_0 = r_wr_ptr;
        ram_wdata     = data_in;
        ram_cs_0      = w_wr_accept && !rst;
        ram_we_0      = w_wr_accept && !rst;
        ram_oe_0      = 1'b0;
        ram_address_1 = r_rd_ptr;
        ram_cs_1      = 1'b1;
        ram_we_1      = 1'b0;
        ram_oe_1      = 1'b1;
    end

    assign data_out  = r_data_out;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
